// File: rtl/shift_pipe.sv
// Qualified delay line: DEPTH stages of WIDTH-bit words with per-stage valid,
// parallel load, flush, runtime tap select and a registered occupancy count.
module shift_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int TAPW  = $clog2(DEPTH),
    parameter int OCCW  = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   flush,
    input  logic                   load,
    input  logic [WIDTH*DEPTH-1:0] load_data,
    input  logic [WIDTH-1:0]       d,
    input  logic                   d_vld,
    input  logic [TAPW-1:0]        tap_sel,
    output logic [WIDTH-1:0]       q,
    output logic                   q_vld,
    output logic [WIDTH-1:0]       tap_q,
    output logic                   tap_vld,
    output logic [OCCW-1:0]        occ
);

    logic [WIDTH-1:0] r_stage [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [OCCW-1:0]  r_occ;
    logic [WIDTH-1:0] w_tap_q;
    logic             w_tap_vld;

    // Incoming valid adds one, the valid leaving the last stage removes one.
    // Modular arithmetic keeps the result exact even if the sum transiently
    // exceeds the OCCW range (e.g. DEPTH = 2**OCCW - 1).
    function automatic logic [OCCW-1:0] f_occ_next(
        input logic [OCCW-1:0] occ_cur,
        input logic            vld_in,
        input logic            vld_out
    );
        return occ_cur + OCCW'(vld_in) - OCCW'(vld_out);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
            r_vld <= '0;
            r_occ <= '0;
        end else if (flush) begin
            r_vld <= '0;
            r_occ <= '0;
        end else if (load) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= load_data[i*WIDTH +: WIDTH];
            end
            r_vld <= '1;
            r_occ <= OCCW'(DEPTH);
        end else if (en) begin
            r_stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
            r_vld <= {r_vld[DEPTH-2:0], d_vld};
            r_occ <= f_occ_next(r_occ, d_vld, r_vld[DEPTH-1]);
        end
    end

    // Out-of-range selects (non-power-of-2 DEPTH) read as an empty stage.
    always_comb begin
        w_tap_q   = '0;
        w_tap_vld = 1'b0;
        if (int'(tap_sel) < DEPTH) begin
            w_tap_q   = r_stage[tap_sel];
            w_tap_vld = r_vld[tap_sel];
        end
    end

    assign q       = r_stage[DEPTH-1];
    assign q_vld   = r_vld[DEPTH-1];
    assign occ     = r_occ;
    assign tap_q   = w_tap_q;
    assign tap_vld = w_tap_vld;

endmodule
